sys_mem_port_arbiter: RTL and testbench

//  Parametrised shared-memory subsystem for the system top: NUM_CH request channels
//  (fetch, load, store, ...) arbitrated round-robin onto one single-port word RAM
//  of DEPTH words, with a fixed-latency response pipeline back to the originating channel.

---
 rtl/sys_mem_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/sys_mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_sys_mem_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys_mem_pkg
//  Purpose  : Shared types and RISC-V exception codes for the memory port arbiter
//  Revision : 1.0  initial release
// ============================================================================
package sys_mem_pkg;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_INST_FAULT     = 4'd1;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } exc_t;

    // Access fault outranks misalignment; the unused op encoding behaves as a load.
    function automatic exc_t check_exc(op_t op, logic fault, logic misalign);
        exc_t e;
        e.valid = fault | misalign;
        case (op)
            OP_FETCH: e.code = fault ? EXC_INST_FAULT  : EXC_INST_MISALIGN;
            OP_STORE: e.code = fault ? EXC_STORE_FAULT : EXC_STORE_MISALIGN;
            default:  e.code = fault ? EXC_LOAD_FAULT  : EXC_LOAD_MISALIGN;
        endcase
        if (!e.valid) begin
            e.code = 4'd0;
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter, one-hot grant, pointer moves past the winner
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_grant_valid
);

    localparam int c_IDX_W = $clog2(N);

    logic [c_IDX_W-1:0] r_ptr;
    int                 w_k;

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_k           = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!o_grant_valid && i_req[w_k]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = c_IDX_W'(w_k);
                o_grant[w_k]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_grant_valid) begin
            r_ptr <= (int'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sys_mem_port_arbiter
//  Purpose  : NUM_CH round-robin request channels onto one single-port word RAM
//             with a fixed-latency, in-order response pipeline
//  Revision : 1.0  initial release
// ============================================================================
module sys_mem_port_arbiter
    import sys_mem_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 16384,
    parameter logic [XLEN-1:0] BASE_ADDR = 'h8000_0000,
    parameter int              NUM_CH    = 3,
    parameter int              LATENCY   = 2,
    parameter                  INIT_FILE = ""
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*2-1:0]        req_op,
    input  logic [NUM_CH*XLEN-1:0]     req_addr,
    input  logic [NUM_CH*XLEN-1:0]     req_wdata,
    input  logic [NUM_CH*(XLEN/8)-1:0] req_wstrb,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [NUM_CH*XLEN-1:0]     rsp_rdata,
    output logic [NUM_CH*5-1:0]        rsp_exc
);

    localparam int            c_BYTES = XLEN / 8;
    localparam int            c_OFF_W = $clog2(c_BYTES);
    localparam int            c_AW    = $clog2(DEPTH);
    localparam int            c_CH_W  = $clog2(NUM_CH);
    localparam logic [XLEN:0] c_SPAN  = {{(XLEN-31){1'b0}}, 32'(DEPTH * c_BYTES)};

    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_grant;
    logic [c_CH_W-1:0]  w_gidx;
    logic               w_gvalid;
    op_t                w_op;
    logic [XLEN-1:0]    w_addr;
    logic [XLEN-1:0]    w_wdata;
    logic [c_BYTES-1:0] w_wstrb;
    logic [XLEN:0]      w_off;
    logic               w_fault;
    logic               w_misalign;
    logic [c_AW-1:0]    w_idx;
    exc_t               w_exc;
    logic               w_write;
    logic               w_read;

    logic [XLEN-1:0]    r_mem     [DEPTH];
    logic [XLEN-1:0]    r_p_rdata [LATENCY];
    logic               r_p_valid [LATENCY];
    logic [c_CH_W-1:0]  r_p_ch    [LATENCY];
    exc_t               r_p_exc   [LATENCY];

    // Masking requests while RESET is low keeps req_ready low and blocks RAM writes.
    assign w_req = RESET ? req_valid : '0;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk           (CLK),
        .rst_n         (RESET),
        .i_req         (w_req),
        .o_grant       (w_grant),
        .o_grant_idx   (w_gidx),
        .o_grant_valid (w_gvalid)
    );

    assign req_ready = w_grant;

    assign w_op    = op_t'(req_op[w_gidx*2 +: 2]);
    assign w_addr  = req_addr[w_gidx*XLEN +: XLEN];
    assign w_wdata = req_wdata[w_gidx*XLEN +: XLEN];
    assign w_wstrb = req_wstrb[w_gidx*c_BYTES +: c_BYTES];

    // One extra bit keeps the upper range bound from wrapping near the top of the address space.
    assign w_off      = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_fault    = (w_addr < BASE_ADDR) || (w_off >= c_SPAN);
    assign w_misalign = |w_addr[c_OFF_W-1:0];
    assign w_idx      = w_off[c_OFF_W +: c_AW];
    assign w_exc      = check_exc(w_op, w_fault, w_misalign);
    assign w_write    = w_gvalid && !w_exc.valid && (w_op == OP_STORE);
    assign w_read     = w_gvalid && !w_exc.valid && (w_op != OP_STORE);

    always_ff @(posedge CLK) begin
        if (w_write) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (w_wstrb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
        r_p_rdata[0] <= w_read ? r_mem[w_idx] : '0;
        for (int s = 1; s < LATENCY; s++) begin
            r_p_rdata[s] <= r_p_rdata[s-1];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_p_valid[s] <= 1'b0;
                r_p_ch[s]    <= '0;
                r_p_exc[s]   <= '0;
            end
        end else begin
            r_p_valid[0] <= w_gvalid;
            r_p_ch[0]    <= w_gidx;
            r_p_exc[0]   <= w_exc;
            for (int s = 1; s < LATENCY; s++) begin
                r_p_valid[s] <= r_p_valid[s-1];
                r_p_ch[s]    <= r_p_ch[s-1];
                r_p_exc[s]   <= r_p_exc[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_exc   = '0;
        if (r_p_valid[LATENCY-1]) begin
            rsp_valid[r_p_ch[LATENCY-1]]                = 1'b1;
            rsp_rdata[r_p_ch[LATENCY-1]*XLEN +: XLEN]   = r_p_rdata[LATENCY-1];
            rsp_exc[r_p_ch[LATENCY-1]*5 +: 5]           = r_p_exc[LATENCY-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_mem_port_arbiter
//  Purpose  : Self-checking bench for two configurations of sys_mem_port_arbiter
//  Revision : 1.0  initial release
// ============================================================================
module tb_sys_mem_port_arbiter;

    localparam int          c_DEPTH = 256;
    localparam logic [63:0] c_BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int sel, xlen, nch, lat;

    logic [7:0]  v_valid;
    logic [1:0]  v_op    [8];
    logic [63:0] v_addr  [8];
    logic [63:0] v_wdata [8];
    logic [7:0]  v_wstrb [8];

    logic [7:0]  o_ready, o_rvalid;
    logic [63:0] o_rdata [8];
    logic [4:0]  o_exc   [8];

    logic [2:0]   a_valid, a_ready, a_rvalid;
    logic [5:0]   a_op;
    logic [95:0]  a_addr, a_wdata, a_rdata;
    logic [11:0]  a_wstrb;
    logic [14:0]  a_exc;
    logic [1:0]   b_valid, b_ready, b_rvalid;
    logic [3:0]   b_op;
    logic [127:0] b_addr, b_wdata, b_rdata;
    logic [15:0]  b_wstrb;
    logic [9:0]   b_exc;

    sys_mem_port_arbiter #(
        .XLEN(32), .DEPTH(c_DEPTH), .BASE_ADDR(32'h8000_0000), .NUM_CH(3), .LATENCY(2), .INIT_FILE("")
    ) u_dut_a (
        .CLK(clk), .RESET(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
        .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_exc(a_exc)
    );

    sys_mem_port_arbiter #(
        .XLEN(64), .DEPTH(c_DEPTH), .BASE_ADDR(64'h8000_0000), .NUM_CH(2), .LATENCY(1), .INIT_FILE("")
    ) u_dut_b (
        .CLK(clk), .RESET(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_exc(b_exc)
    );

    always_comb begin
        a_valid = '0; a_op = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = '0; b_op = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        for (int i = 0; i < 3; i++) begin
            a_valid[i]         = (sel == 0) && v_valid[i];
            a_op[i*2 +: 2]     = v_op[i];
            a_addr[i*32 +: 32] = v_addr[i][31:0];
            a_wdata[i*32 +: 32] = v_wdata[i][31:0];
            a_wstrb[i*4 +: 4]  = v_wstrb[i][3:0];
        end
        for (int i = 0; i < 2; i++) begin
            b_valid[i]          = (sel == 1) && v_valid[i];
            b_op[i*2 +: 2]      = v_op[i];
            b_addr[i*64 +: 64]  = v_addr[i];
            b_wdata[i*64 +: 64] = v_wdata[i];
            b_wstrb[i*8 +: 8]   = v_wstrb[i];
        end
    end

    always_comb begin
        o_ready = '0; o_rvalid = '0;
        for (int i = 0; i < 8; i++) begin
            o_rdata[i] = '0;
            o_exc[i]   = '0;
        end
        if (sel == 0) begin
            for (int i = 0; i < 3; i++) begin
                o_ready[i]  = a_ready[i];
                o_rvalid[i] = a_rvalid[i];
                o_rdata[i]  = {32'h0, a_rdata[i*32 +: 32]};
                o_exc[i]    = a_exc[i*5 +: 5];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                o_ready[i]  = b_ready[i];
                o_rvalid[i] = b_rvalid[i];
                o_rdata[i]  = b_rdata[i*64 +: 64];
                o_exc[i]    = b_exc[i*5 +: 5];
            end
        end
    end

    // Reference model: word memory, expected-response queue, round-robin pointer
    typedef struct {
        int          due;
        int          ch;
        logic [63:0] rdata;
        bit          known;
        logic [4:0]  exc;
    } rsp_t;

    typedef struct {
        logic [2:0] mask;
        logic [2:0] exp_grant;
    } vec_t;

    logic [63:0] mm [int];
    rsp_t        q [$];
    int          ptr, cyc;
    int          n_tests, n_fail;
    logic [63:0] last_rdata [8];
    logic [4:0]  last_exc   [8];
    logic [7:0]  last_ready;
    int          gnt_log [$];
    int          rsp_log [$];
    int          fault_code [3] = '{1, 5, 7};
    int          mis_code   [3] = '{0, 4, 6};
    vec_t        tbl [8];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(int g);
        int          bytes;
        logic [63:0] a, span;
        bit          fault, mis;
        logic [4:0]  exc;
        int          idx;
        logic [63:0] rd;
        bit          known;
        bytes = xlen / 8;
        a     = v_addr[g];
        span  = 64'(c_DEPTH * bytes);
        fault = (a < c_BASE) || (a >= c_BASE + span);
        mis   = (a % bytes) != 0;
        exc   = fault ? {1'b1, 4'(fault_code[v_op[g]])} : mis ? {1'b1, 4'(mis_code[v_op[g]])} : 5'h0;
        idx   = int'((a - c_BASE) / bytes);
        rd    = '0;
        known = 1'b1;
        if (!exc[4]) begin
            if (v_op[g] == 2'd2) begin
                if (!mm.exists(idx)) mm[idx] = '0;
                for (int b = 0; b < bytes; b++)
                    if (v_wstrb[g][b]) mm[idx][b*8 +: 8] = v_wdata[g][b*8 +: 8];
            end else if (mm.exists(idx)) begin
                rd = mm[idx];
            end else begin
                known = 1'b0;
            end
        end
        q.push_back('{cyc + lat, g, rd, known, exc});
        ptr = (g + 1) % nch;
    endtask

    task automatic step();
        int          g;
        logic [7:0]  exp_ready, exp_rv;
        rsp_t        r;
        logic [63:0] exp_rd [8];
        logic [4:0]  exp_ex [8];
        bit          exp_kn [8];
        @(negedge clk);
        g = -1;
        if (rst_n) begin
            for (int k = 0; k < nch; k++) begin
                int c;
                c = (ptr + k) % nch;
                if (g < 0 && v_valid[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? (8'd1 << g) : 8'd0;
        last_ready = o_ready;
        check("req_ready", o_ready, exp_ready);
        for (int i = 0; i < nch; i++) if (o_ready[i]) gnt_log.push_back(i);
        exp_rv = '0;
        for (int i = 0; i < 8; i++) begin
            exp_rd[i] = '0; exp_ex[i] = '0; exp_kn[i] = 1'b1;
        end
        while (q.size() > 0 && q[0].due <= cyc) begin
            r = q.pop_front();
            if (r.due == cyc) begin
                exp_rv[r.ch] = 1'b1;
                exp_rd[r.ch] = r.rdata;
                exp_ex[r.ch] = r.exc;
                exp_kn[r.ch] = r.known;
            end
        end
        check("rsp_valid", o_rvalid, exp_rv);
        for (int i = 0; i < nch; i++) begin
            if (o_rvalid[i]) begin
                rsp_log.push_back(i);
                last_rdata[i] = o_rdata[i];
                last_exc[i]   = o_exc[i];
            end
            if (exp_rv[i]) begin
                if (exp_kn[i]) check("rsp_rdata", o_rdata[i], exp_rd[i]);
                check("rsp_exc", o_exc[i], exp_ex[i]);
            end
        end
        @(posedge clk);
        if (g >= 0) apply(g);
        cyc++;
        #1;
    endtask

    task automatic clr();
        v_valid = '0;
    endtask

    task automatic set_req(int ch, int op, logic [63:0] addr, logic [63:0] wd, logic [7:0] strb);
        v_valid[ch] = 1'b1;
        v_op[ch]    = 2'(op);
        v_addr[ch]  = addr;
        v_wdata[ch] = wd;
        v_wstrb[ch] = strb;
    endtask

    task automatic one(int ch, int op, logic [63:0] addr, logic [63:0] wd, logic [7:0] strb);
        clr();
        set_req(ch, op, addr, wd, strb);
        step();
        clr();
    endtask

    task automatic idle(int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_pulse(int n);
        clr();
        rst_n = 1'b0;
        q.delete();
        ptr = 0;
        for (int i = 0; i < n; i++) step();
        for (int i = 0; i < nch; i++) begin
            check("reset_rdata", o_rdata[i], 64'h0);
            check("reset_exc", o_exc[i], 64'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic preload();
        int bytes;
        bytes = xlen / 8;
        for (int w = 0; w < 16; w++)
            one(0, 2, c_BASE + 64'(w * bytes), {$urandom(), $urandom()}, 8'hFF);
        idle(lat + 1);
    endtask

    // Scenarios 1-4 plus a randomized phase; shared by both configurations
    task automatic common_scenarios();
        int          bytes;
        logic [63:0] old, w0;
        bytes = xlen / 8;
        preload();

        w0 = mm[0];
        one(0, 0, c_BASE, '0, '0);
        idle(lat + 1);
        check("s1_fetch_rdata", last_rdata[0], w0);
        check("s1_fetch_exc", last_exc[0], 64'h0);

        old = mm[8 / bytes];
        one(nch - 1, 2, c_BASE + 64'd8, 64'hDEAD_BEEF, 8'h03);
        one(1, 1, c_BASE + 64'd8, '0, '0);
        idle(lat + 1);
        check("s2_partial_store", last_rdata[1], {old[63:16], 16'hBEEF});

        reset_pulse(1);
        gnt_log.delete();
        rsp_log.delete();
        clr();
        for (int c = 0; c < nch; c++) set_req(c, 1, c_BASE + 64'(c * bytes), '0, '0);
        for (int i = 0; i < 6; i++) step();
        idle(lat + 1);
        check("s3_grant_count", gnt_log.size(), 6);
        check("s3_rsp_count", rsp_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size() && i < rsp_log.size(); i++) begin
            check("s3_grant_order", gnt_log[i], i % nch);
            check("s3_rsp_order", rsp_log[i], i % nch);
        end

        one(1, 1, c_BASE + 64'(bytes / 2), '0, '0);
        idle(lat + 1);
        check("s4_load_misalign", last_exc[1], 5'h14);
        one(0, 0, c_BASE - 64'd4, '0, '0);
        idle(lat + 1);
        check("s4_fetch_fault", last_exc[0], 5'h11);
        w0 = mm[0];
        one(nch - 1, 2, c_BASE + 64'(c_DEPTH * bytes), {$urandom(), $urandom()}, 8'hFF);
        idle(lat + 1);
        check("s4_store_fault", last_exc[nch-1], 5'h17);
        one(0, 2, c_BASE + 64'd1, {$urandom(), $urandom()}, 8'hFF);
        one(0, 1, c_BASE, '0, '0);
        idle(lat + 1);
        check("s4_ram_unchanged", last_rdata[0], w0);

        for (int t = 0; t < 300; t++) begin
            clr();
            for (int c = 0; c < nch; c++) begin
                int          r, w;
                logic [63:0] addr;
                r = int'($urandom_range(0, 15));
                w = int'($urandom_range(0, 15));
                addr = c_BASE + 64'(w * bytes);
                if (r == 0) addr = addr + 64'($urandom_range(1, bytes - 1));
                else if (r == 1) addr = c_BASE + 64'(c_DEPTH * bytes) + 64'(w * bytes);
                else if (r == 2) addr = c_BASE - 64'(bytes);
                if ($urandom_range(0, 2) != 0)
                    set_req(c, int'($urandom_range(0, 2)), addr, {$urandom(), $urandom()},
                            8'($urandom_range(0, 255)));
            end
            step();
        end
        idle(lat + 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        ptr     = 0;
        v_valid = '0;
        for (int i = 0; i < 8; i++) begin
            v_op[i] = '0; v_addr[i] = '0; v_wdata[i] = '0; v_wstrb[i] = '0;
            last_rdata[i] = '0; last_exc[i] = '0;
        end
        // ptr starts at 0 after reset; rows chained cycle to cycle
        tbl[0] = '{3'b111, 3'b001};
        tbl[1] = '{3'b101, 3'b100};
        tbl[2] = '{3'b110, 3'b010};
        tbl[3] = '{3'b011, 3'b001};
        tbl[4] = '{3'b000, 3'b000};
        tbl[5] = '{3'b001, 3'b001};
        tbl[6] = '{3'b100, 3'b100};
        tbl[7] = '{3'b010, 3'b010};

        sel = 0; xlen = 32; nch = 3; lat = 2;
        reset_pulse(2);
        common_scenarios();

        begin : s5_reset_mid_flight
            int          n_before;
            logic [63:0] data;
            data = 64'h0000_0000_C0FF_EE11;
            one(0, 2, c_BASE + 64'd12, data, 8'hFF);
            one(1, 1, c_BASE + 64'd4, '0, '0);
            one(2, 1, c_BASE + 64'd8, '0, '0);
            n_before = rsp_log.size();
            reset_pulse(1);
            for (int r = 0; r < 8; r++) begin
                clr();
                for (int c = 0; c < 3; c++)
                    if (tbl[r].mask[c]) set_req(c, 1, c_BASE + 64'(c * 4), '0, '0);
                step();
                check("s5_table_grant", last_ready, {5'b0, tbl[r].exp_grant});
            end
            idle(lat + 1);
            check("s5_suppressed", rsp_log.size() - n_before, 7);
            one(1, 1, c_BASE + 64'd12, '0, '0);
            idle(lat + 1);
            check("s5_store_kept", last_rdata[1], data);
        end

        sel = 1; xlen = 64; nch = 2; lat = 1;
        mm.delete();
        reset_pulse(2);
        common_scenarios();
        one(0, 1, c_BASE + 64'd4, '0, '0);
        idle(lat + 1);
        check("s6_align8", last_exc[0], 5'h14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
